uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
- Downstream UART transmit stage fed by the TX controller.
- Accepts one parallel byte per Data_Valid handshake and serialises it onto TX_OUT as a UART frame: start, 8 data bits LSB first, optional parity, stop.
- Returns Busy to the controller, which uses Busy to sequence single-byte reads and two-byte ALU results (LS byte first, then MS byte).
- Runs on the divided TX baud clock: one bit per TXCont_CLK cycle.

Parameters:
- DATA_WIDTH, 8, payload bits per frame; counter width is sized from it.

Ports:
- TXCont_CLK  in  1  TX baud clock; all state changes on the rising edge
- TXCont_RST  in  1  asynchronous, active-low reset
- P_DATA  in  DATA_WIDTH  byte to send; sampled only at acceptance
- Data_Valid  in  1  level request from the controller, held until Busy is seen high
- PAR_EN  in  1  1 = insert a parity bit; sampled at acceptance
- PAR_TYP  in  1  0 = even, 1 = odd; sampled at acceptance
- TX_OUT  out  1  serial line, registered, idles high
- Busy  out  1  registered; high from the start bit through the stop bit

Behaviour:
- Reset (async, TXCont_RST=0):
  - state=IDLE; TX_OUT=1; Busy=0; data shift register, bit counter, parity latch and PAR_EN latch all cleared.
  - Reset mid-frame aborts the frame immediately: line returns high and the byte is dropped, not resumed.
- States: IDLE, START, DATA, PARITY, STOP. TX_OUT and Busy are registered and reflect the current state.
- IDLE:
  - Outputs: TX_OUT=1, Busy=0.
  - If Data_Valid=1, accept the request and latch:
    - P_DATA into the shift register;
    - PAR_EN;
    - the parity bit: even = XOR-reduce(P_DATA); odd = XNOR-reduce(P_DATA).
  - Then go to START.
- START: TX_OUT=0, Busy=1, bit counter=0; next state DATA.
- DATA:
  - TX_OUT = data[counter], LSB first; Busy=1.
  - When counter = DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP. Otherwise increment the counter.
- PARITY: TX_OUT = latched parity bit, Busy=1; next state STOP.
- STOP: TX_OUT=1, Busy=1; next state IDLE unconditionally.
- Latency: Data_Valid sampled high in IDLE at edge N -> start bit and Busy=1 from edge N to edge N+1.
- Frame length: 10 cycles (PAR_EN=0) or 11 cycles (PAR_EN=1) of Busy=1.
- Minimum one IDLE cycle (Busy=0, TX_OUT=1) between frames. This is the Busy low edge the controller waits on before issuing the MS byte.
- Data_Valid while Busy=1: ignored; no queuing.
  - A request still high when IDLE is re-entered is accepted as a new byte. The controller guarantees it drops Data_Valid once Busy rises.
- Changes to P_DATA, PAR_EN or PAR_TYP mid-frame have no effect on the frame in progress.
- Data_Valid and reset released on the same edge: reset dominates; acceptance happens on the first edge with TXCont_RST=1.

Test Plan:
- No parity: PAR_EN=0, P_DATA=0xA5, Data_Valid pulsed in IDLE -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1. Busy high exactly 10 cycles starting the cycle after acceptance, then Busy=0 and TX_OUT=1.
- Even parity: PAR_EN=1, PAR_TYP=0:
  - 0xA5 -> data bits as above, parity 0, stop 1; Busy 11 cycles.
  - 0x01 -> parity 1.
- Odd parity: PAR_EN=1, PAR_TYP=1, 0x01 -> parity bit 0; 0x00 -> parity bit 1.
- ALU two-byte result 0x1234, with Data_Valid driven as the controller does (held until Busy rises, re-asserted after Busy falls) -> two frames, 0x34 then 0x12, separated by exactly one IDLE cycle with Busy=0.
- Ignore while busy: toggle Data_Valid with P_DATA=0xFF in mid-frame of a 0x0F transfer -> frame still carries 0x0F; no extra frame while Data_Valid is low at frame end.
- Reset mid-frame: assert TXCont_RST during data bit 3 -> TX_OUT=1 and Busy=0 asynchronously. After release with Data_Valid=0, the line stays idle; a new request sends a full, correct frame.

Source files
------------

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake and serial line between the TX controller and the serializer.
// The controller drives the byte and its parity options; the serializer returns the line and Busy.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  Busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output Busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, DATA_WIDTH data bits LSB first, optional parity, stop bit.
// Sends one bit per baud clock; TX_OUT and Busy are registered.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  TXCont_CLK,
  input  logic                  TXCont_RST,
  uart_tx_serializer_if.slave   bus
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_bit;
  logic                  par_en_lat;
  logic                  tx_out;
  logic                  busy;

  assign bus.TX_OUT = tx_out;
  assign bus.Busy   = busy;

  // Outputs are loaded on the same edge as the state, so they always describe the state just entered.
  always_ff @(posedge TXCont_CLK or negedge TXCont_RST) begin
    if (!TXCont_RST) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      par_en_lat <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Data_Valid) begin
            shift_reg  <= bus.P_DATA;
            par_en_lat <= bus.PAR_EN;
            par_bit    <= (^bus.P_DATA) ^ bus.PAR_TYP;
            state      <= START;
            tx_out     <= 1'b0;
            busy       <= 1'b1;
          end else begin
            tx_out <= 1'b1;
            busy   <= 1'b0;
          end
        end
        START: begin
          bit_cnt   <= '0;
          tx_out    <= shift_reg[0];
          shift_reg <= shift_reg >> 1;
          busy      <= 1'b1;
          state     <= DATA;
        end
        DATA: begin
          busy <= 1'b1;
          if (bit_cnt == LAST_BIT) begin
            if (par_en_lat) begin
              state  <= PARITY;
              tx_out <= par_bit;
            end else begin
              state  <= STOP;
              tx_out <= 1'b1;
            end
          end else begin
            bit_cnt   <= bit_cnt + CNT_W'(1);
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
          end
        end
        PARITY: begin
          state  <= STOP;
          tx_out <= 1'b1;
          busy   <= 1'b1;
        end
        STOP: begin
          // Always pass through IDLE so the controller sees Busy drop between bytes.
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: directed test-plan frames plus random frames,
// each compared bit by bit against a frame built from the UART framing rules.
module tb_uart_tx_serializer;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  uart_tx_serializer_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_serializer #(.DATA_WIDTH(8)) dut (
    .TXCont_CLK (clk),
    .TXCont_RST (rst_n),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected line image of one frame: start 0, data LSB first, optional parity, stop 1.
  task automatic build_frame(input logic [7:0] data, input logic pe, input logic pt,
                             output logic frame [$]);
    int ones;
    frame = {};
    ones  = 0;
    frame.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      frame.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pe) frame.push_back(((ones % 2) == 1) ^ pt);
    frame.push_back(1'b1);
  endtask

  // Called at a sample point with the line idle; returns at the first idle sample after the frame.
  task automatic apply_stimulus(input string name, input logic [7:0] data, input logic pe,
                                input logic pt, input bit noisy);
    logic frame [$];
    build_frame(data, pe, pt, frame);
    check_output({name, "_idle_tx"}, bus.TX_OUT, 1'b1);
    check_output({name, "_idle_busy"}, bus.Busy, 1'b0);
    bus.P_DATA     = data;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    next_cycle();
    check_output({name, "_start_busy"}, bus.Busy, 1'b1);
    check_output({name, "_start_bit"}, bus.TX_OUT, frame[0]);
    bus.Data_Valid = 1'b0;
    for (int i = 1; i < frame.size(); i++) begin
      if (noisy) begin
        bus.Data_Valid = (i >= 2 && i <= 6) ? i[0] : 1'b0;
        bus.P_DATA     = 8'hFF;
        bus.PAR_EN     = 1'($urandom);
        bus.PAR_TYP    = 1'($urandom);
      end
      next_cycle();
      check_output($sformatf("%s_bit%0d", name, i), bus.TX_OUT, frame[i]);
      check_output($sformatf("%s_busy%0d", name, i), bus.Busy, 1'b1);
    end
    next_cycle();
    check_output({name, "_end_tx"}, bus.TX_OUT, 1'b1);
    check_output({name, "_end_busy"}, bus.Busy, 1'b0);
  endtask

  initial begin
    logic [7:0] rdata;
    logic       rpe;
    logic       rpt;
    logic [7:0] rst_data;

    errors         = 0;
    checks         = 0;
    rst_n          = 1'b0;
    bus.Data_Valid = 1'b0;
    bus.P_DATA     = 8'h00;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;

    $display("[TB] reset");
    repeat (3) next_cycle();
    check_output("reset_tx", bus.TX_OUT, 1'b1);
    check_output("reset_busy", bus.Busy, 1'b0);
    rst_n = 1'b1;
    next_cycle();

    $display("[TB] directed frames");
    apply_stimulus("nopar_a5", 8'hA5, 1'b0, 1'b0, 1'b0);
    apply_stimulus("even_a5", 8'hA5, 1'b1, 1'b0, 1'b0);
    apply_stimulus("even_01", 8'h01, 1'b1, 1'b0, 1'b0);
    apply_stimulus("odd_01", 8'h01, 1'b1, 1'b1, 1'b0);
    apply_stimulus("odd_00", 8'h00, 1'b1, 1'b1, 1'b0);

    $display("[TB] two-byte ALU result");
    apply_stimulus("alu_ls", 8'h34, 1'b0, 1'b0, 1'b0);
    apply_stimulus("alu_ms", 8'h12, 1'b0, 1'b0, 1'b0);

    $display("[TB] requests while busy");
    apply_stimulus("noisy_0f", 8'h0F, 1'b1, 1'b0, 1'b1);
    next_cycle();
    check_output("noisy_no_extra_tx", bus.TX_OUT, 1'b1);
    check_output("noisy_no_extra_busy", bus.Busy, 1'b0);

    $display("[TB] reset mid-frame");
    rst_data       = 8'hC3;
    bus.P_DATA     = rst_data;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = 1'b0;
    bus.Data_Valid = 1'b1;
    next_cycle();
    bus.Data_Valid = 1'b0;
    repeat (4) next_cycle();
    check_output("rst_pre_bit3", bus.TX_OUT, rst_data[3]);
    check_output("rst_pre_busy", bus.Busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_async_tx", bus.TX_OUT, 1'b1);
    check_output("rst_async_busy", bus.Busy, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      check_output($sformatf("rst_idle_tx%0d", i), bus.TX_OUT, 1'b1);
      check_output($sformatf("rst_idle_busy%0d", i), bus.Busy, 1'b0);
    end
    apply_stimulus("post_rst", 8'h96, 1'b1, 1'b1, 1'b0);

    $display("[TB] random frames");
    for (int n = 0; n < 8; n++) begin
      rdata = 8'($urandom);
      rpe   = 1'($urandom);
      rpt   = 1'($urandom);
      apply_stimulus($sformatf("rand%0d", n), rdata, rpe, rpt, (n % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
